// File: rtl/dino_pkg.sv
// Shared types and helpers for the dino runner game sequencer.
package dino_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HIT  = 2'b10,
    ST_OVER = 2'b11
  } dino_state_e;

  typedef logic [3:0]       bcd_digit_t;
  typedef bcd_digit_t [3:0] bcd_score_t;

  localparam bcd_score_t BCD_MAX = 16'h9999;

  // True when a > b, comparing digits most significant first.
  function automatic logic bcd_gt(input bcd_score_t a, input bcd_score_t b);
    logic gt;
    logic done;
    gt   = 1'b0;
    done = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (!done && (a[i] != b[i])) begin
        gt   = (a[i] > b[i]);
        done = 1'b1;
      end
    end
    return gt;
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter, saturating at 9999, with a pulse on every
// carry out of the tens digit into the hundreds digit.
module bcd_counter4
  import dino_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_inc,
  output logic [15:0] o_score,
  output logic        o_hund_carry
);

  bcd_score_t r_score;
  bcd_score_t w_inc_val;
  logic       w_sat;

  assign w_sat = (r_score == BCD_MAX);

  // Ripple a +1 through the digits, wrapping 9 -> 0 with carry.
  always_comb begin : inc_chain
    logic c;
    w_inc_val = r_score;
    c         = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r_score[i] == 4'd9) begin
          w_inc_val[i] = 4'd0;
        end else begin
          w_inc_val[i] = r_score[i] + 4'd1;
          c            = 1'b0;
        end
      end
    end
  end

  // Combinational so the speed register updates on the same edge as the score.
  assign o_hund_carry = i_inc && !i_clr && !w_sat &&
                        (r_score[1] == 4'd9) && (r_score[0] == 4'd9);

  // Score register: clear has priority, saturated value is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_score <= '0;
    end else if (i_clr) begin
      r_score <= '0;
    end else if (i_inc && !w_sat) begin
      r_score <= w_inc_val;
    end
  end

  assign o_score = r_score;

endmodule

// File: rtl/dino_game_ctrl.sv
// Dino runner game sequencer: frame tick from vsync, game FSM, score,
// speed level and high score.
//
// state | meaning
// IDLE  | waiting for first jump; last score still displayed
// RUN   | scrolling, scoring, jumps accepted when grounded
// HIT   | frozen for HIT_FRAMES frames after a collision
// OVER  | game over; jump or restart returns to IDLE
module dino_game_ctrl
  import dino_pkg::*;
#(
  parameter int FRAMES_PER_POINT = 6,
  parameter int HIT_FRAMES       = 30,
  parameter int MAX_SPEED        = 7
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        jump_req,
  input  logic        restart_req,
  input  logic        dino_grounded,
  input  logic        collision,
  output logic [1:0]  state,
  output logic        frame_tick,
  output logic        jump_go,
  output logic        scroll_en,
  output logic [2:0]  speed,
  output logic [15:0] score_bcd,
  output logic [15:0] hi_score_bcd
);

  localparam logic [5:0] FPP_LAST = 6'(FRAMES_PER_POINT - 1);
  localparam logic [5:0] HIT_LAST = 6'(HIT_FRAMES - 1);
  localparam logic [2:0] SPD_MAX  = 3'(MAX_SPEED);

  dino_state_e r_state, w_state_nxt;
  logic        r_vs_meta, r_vs_sync, r_vs_prev, r_frame_tick;
  logic        r_hit, w_hit_nxt;
  logic [5:0]  r_frame_cnt, w_frame_cnt_nxt;
  logic [5:0]  r_hit_cnt, w_hit_cnt_nxt;
  logic [2:0]  r_speed;
  logic        r_jump_go, w_jump_go_nxt;
  logic [15:0] r_hi_score;
  logic        w_score_clr, w_score_inc, w_speed_clr, w_hi_load;
  logic        w_hund_carry;
  logic [15:0] w_score;

  // Synchronise vsync (idle-high) and register its falling edge as the frame tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vs_meta    <= 1'b1;
      r_vs_sync    <= 1'b1;
      r_vs_prev    <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_vs_meta    <= vsync;
      r_vs_sync    <= r_vs_meta;
      r_vs_prev    <= r_vs_sync;
      r_frame_tick <= r_vs_prev & ~r_vs_sync;
    end
  end

  // Next-state, counter and command decode; restart overrides everything.
  always_comb begin
    w_state_nxt     = r_state;
    w_hit_nxt       = r_hit;
    w_frame_cnt_nxt = r_frame_cnt;
    w_hit_cnt_nxt   = r_hit_cnt;
    w_jump_go_nxt   = 1'b0;
    w_score_clr     = 1'b0;
    w_score_inc     = 1'b0;
    w_speed_clr     = 1'b0;
    w_hi_load       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (jump_req) begin
          w_state_nxt     = ST_RUN;
          w_score_clr     = 1'b1;
          w_speed_clr     = 1'b1;
          w_frame_cnt_nxt = '0;
          w_jump_go_nxt   = dino_grounded;
        end
      end
      ST_RUN: begin
        w_hit_nxt = r_hit | collision;
        if (r_frame_tick) begin
          if (r_hit || collision) begin
            w_state_nxt   = ST_HIT;
            w_hit_cnt_nxt = HIT_LAST;
          end else if (r_frame_cnt == FPP_LAST) begin
            w_frame_cnt_nxt = '0;
            w_score_inc     = 1'b1;
          end else begin
            w_frame_cnt_nxt = r_frame_cnt + 6'd1;
          end
        end
        if (jump_req && dino_grounded && (w_state_nxt == ST_RUN)) begin
          w_jump_go_nxt = 1'b1;
        end
      end
      ST_HIT: begin
        if (r_frame_tick) begin
          if (r_hit_cnt == 6'd0) begin
            w_state_nxt = ST_OVER;
            w_hi_load   = bcd_gt(w_score, r_hi_score);
          end else begin
            w_hit_cnt_nxt = r_hit_cnt - 6'd1;
          end
        end
      end
      ST_OVER: begin
        if (jump_req) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (restart_req) begin
      w_state_nxt     = ST_IDLE;
      w_jump_go_nxt   = 1'b0;
      w_score_clr     = 1'b1;
      w_score_inc     = 1'b0;
      w_speed_clr     = 1'b1;
      w_hi_load       = 1'b0;
      w_frame_cnt_nxt = '0;
    end
    if (w_state_nxt != r_state) begin
      w_hit_nxt = 1'b0;
    end
  end

  // State, flags, counters, speed and high-score registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_hit       <= 1'b0;
      r_frame_cnt <= '0;
      r_hit_cnt   <= '0;
      r_jump_go   <= 1'b0;
      r_speed     <= '0;
      r_hi_score  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_hit       <= w_hit_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_hit_cnt   <= w_hit_cnt_nxt;
      r_jump_go   <= w_jump_go_nxt;
      if (w_speed_clr) begin
        r_speed <= '0;
      end else if (w_hund_carry && (r_speed < SPD_MAX)) begin
        r_speed <= r_speed + 3'd1;
      end
      if (w_hi_load) begin
        r_hi_score <= w_score;
      end
    end
  end

  bcd_counter4 u_score (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (w_score_clr),
    .i_inc        (w_score_inc),
    .o_score      (w_score),
    .o_hund_carry (w_hund_carry)
  );

  assign state        = r_state;
  assign frame_tick   = r_frame_tick;
  assign jump_go      = r_jump_go;
  assign scroll_en    = (r_state == ST_RUN);
  assign speed        = r_speed;
  assign score_bcd    = w_score;
  assign hi_score_bcd = r_hi_score;

endmodule

// File: tb/tb_dino_game_ctrl.sv
// Directed bench for dino_game_ctrl: a default-parameter instance for the
// game flow and a one-frame-per-point instance to reach score saturation.
module tb_dino_game_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, vsync, jump_req, restart_req, dino_grounded, collision;
  logic [1:0]  state;
  logic        frame_tick, jump_go, scroll_en;
  logic [2:0]  speed;
  logic [15:0] score_bcd, hi_score_bcd;

  logic f_rst, f_vsync, f_jump, f_restart, f_grounded, f_collision;
  logic [1:0]  f_state;
  logic        f_frame_tick, f_jump_go, f_scroll_en;
  logic [2:0]  f_speed;
  logic [15:0] f_score, f_hi_score;

  int n_vec = 0;
  int n_err = 0;

  dino_game_ctrl u_dut (
    .clk(clk), .rst(rst), .vsync(vsync), .jump_req(jump_req),
    .restart_req(restart_req), .dino_grounded(dino_grounded),
    .collision(collision), .state(state), .frame_tick(frame_tick),
    .jump_go(jump_go), .scroll_en(scroll_en), .speed(speed),
    .score_bcd(score_bcd), .hi_score_bcd(hi_score_bcd)
  );

  dino_game_ctrl #(.FRAMES_PER_POINT(1)) u_fast (
    .clk(clk), .rst(f_rst), .vsync(f_vsync), .jump_req(f_jump),
    .restart_req(f_restart), .dino_grounded(f_grounded),
    .collision(f_collision), .state(f_state), .frame_tick(f_frame_tick),
    .jump_go(f_jump_go), .scroll_en(f_scroll_en), .speed(f_speed),
    .score_bcd(f_score), .hi_score_bcd(f_hi_score)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    vsync = 1'b0;
    repeat (3) step();
    vsync = 1'b1;
    repeat (2) step();
  endtask

  task automatic f_frame();
    f_vsync = 1'b0;
    repeat (2) step();
    f_vsync = 1'b1;
    repeat (2) step();
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_state"}, state, 2'b00);
    check_val({tag, "_tick"}, frame_tick, 1'b0);
    check_val({tag, "_jump_go"}, jump_go, 1'b0);
    check_val({tag, "_scroll"}, scroll_en, 1'b0);
    check_val({tag, "_speed"}, speed, 3'd0);
    check_val({tag, "_score"}, score_bcd, 16'h0000);
    check_val({tag, "_hi"}, hi_score_bcd, 16'h0000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks;
    rst = 1'b1; vsync = 1'b1; jump_req = 1'b0; restart_req = 1'b0;
    dino_grounded = 1'b1; collision = 1'b0;
    f_rst = 1'b1; f_vsync = 1'b1; f_jump = 1'b0; f_restart = 1'b0;
    f_grounded = 1'b1; f_collision = 1'b0;
    repeat (3) step();
    check_all_zero("reset");

    // Saturation run on the fast instance: one point per frame.
    f_rst = 1'b0;
    step();
    f_jump = 1'b1;
    step();
    f_jump = 1'b0;
    check_val("fast_run", f_state, 2'b01);
    for (int i = 1; i <= 10011; i++) begin
      f_frame();
      if (i == 600) begin
        check_val("fast_0600", f_score, 16'h0600);
        check_val("fast_spd6", f_speed, 3'd6);
      end
      if (i == 700) begin
        check_val("fast_0700", f_score, 16'h0700);
        check_val("fast_spd7", f_speed, 3'd7);
      end
      if (i == 9999) begin
        check_val("fast_9999", f_score, 16'h9999);
        check_val("fast_spd_9999", f_speed, 3'd7);
      end
    end
    check_val("fast_sat_score", f_score, 16'h9999);
    check_val("fast_sat_speed", f_speed, 3'd7);
    check_val("fast_sat_state", f_state, 2'b01);

    // Main game flow.
    rst = 1'b0;
    step();
    jump_req = 1'b1;
    step();
    jump_req = 1'b0;
    check_val("start_state", state, 2'b01);
    check_val("start_jump_go", jump_go, 1'b1);
    check_val("start_scroll", scroll_en, 1'b1);
    check_val("start_score", score_bcd, 16'h0000);
    step();
    check_val("jump_go_width", jump_go, 1'b0);

    vsync = 1'b0;
    step();
    step();
    check_val("tick_early", frame_tick, 1'b0);
    step();
    check_val("tick_3clk", frame_tick, 1'b1);
    vsync = 1'b1;
    step();
    check_val("tick_width", frame_tick, 1'b0);
    step();
    repeat (4) frame();
    check_val("score_5fr", score_bcd, 16'h0000);

    vsync = 1'b0;
    repeat (3) step();
    check_val("tick_fr6", frame_tick, 1'b1);
    check_val("score_at_tick", score_bcd, 16'h0000);
    vsync = 1'b1;
    step();
    check_val("score_after_tick", score_bcd, 16'h0001);
    step();

    repeat (54) frame();
    check_val("score_60fr", score_bcd, 16'h0010);
    check_val("speed_60fr", speed, 3'd0);
    repeat (534) frame();
    check_val("score_0099", score_bcd, 16'h0099);
    check_val("speed_0099", speed, 3'd0);
    repeat (6) frame();
    check_val("score_0100", score_bcd, 16'h0100);
    check_val("speed_0100", speed, 3'd1);

    dino_grounded = 1'b0;
    jump_req = 1'b1;
    step();
    jump_req = 1'b0;
    check_val("jump_air", jump_go, 1'b0);
    check_val("jump_air_state", state, 2'b01);
    dino_grounded = 1'b1;
    step();
    check_val("jump_no_queue", jump_go, 1'b0);
    jump_req = 1'b1;
    step();
    jump_req = 1'b0;
    check_val("jump_run", jump_go, 1'b1);

    vsync = 1'b0;
    step();
    collision = 1'b1;
    step();
    collision = 1'b0;
    step();
    check_val("hit_tick", frame_tick, 1'b1);
    check_val("hit_pre_state", state, 2'b01);
    vsync = 1'b1;
    step();
    check_val("hit_state", state, 2'b10);
    check_val("hit_scroll", scroll_en, 1'b0);
    check_val("hit_score", score_bcd, 16'h0100);
    step();

    repeat (29) frame();
    check_val("hit_29fr", state, 2'b10);
    jump_req = 1'b1;
    step();
    jump_req = 1'b0;
    check_val("jump_in_hit", jump_go, 1'b0);
    frame();
    check_val("over_state", state, 2'b11);
    check_val("over_hi", hi_score_bcd, 16'h0100);
    check_val("over_score", score_bcd, 16'h0100);

    restart_req = 1'b1;
    jump_req = 1'b1;
    step();
    restart_req = 1'b0;
    jump_req = 1'b0;
    check_val("restart_state", state, 2'b00);
    check_val("restart_jump_go", jump_go, 1'b0);
    check_val("restart_score", score_bcd, 16'h0000);
    check_val("restart_hi", hi_score_bcd, 16'h0100);

    // Asynchronous reset in the middle of HIT.
    jump_req = 1'b1;
    step();
    jump_req = 1'b0;
    check_val("rerun_state", state, 2'b01);
    collision = 1'b1;
    step();
    collision = 1'b0;
    frame();
    check_val("rehit_state", state, 2'b10);
    frame();
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    step();
    step();
    rst = 1'b0;
    ticks = 0;
    repeat (8) begin
      step();
      if (frame_tick) ticks++;
    end
    check_val("no_tick_after_rst", ticks, 0);
    vsync = 1'b0;
    repeat (3) step();
    check_val("tick_after_rst", frame_tick, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
